// File: rtl/sn_popcount_pipe_if.sv
// Stream interface for sn_popcount_pipe: input beats with frame flags and a count/sum result.
// Defining SNC_THERM_OUT_EN adds the sorted thermometer output signal.
interface sn_popcount_pipe_if #(
  parameter int N_IN  = 15,
  parameter int ACC_W = 16
);
  logic [N_IN-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic             in_acc;
  logic             in_last;
  logic [ACC_W-1:0] out_cnt;
  logic             out_valid;
  logic             out_ready;
  logic             out_sat;
`ifdef SNC_THERM_OUT_EN
  logic [N_IN-1:0]  out_therm;
`endif

  modport master (
    output in_data, in_valid, in_acc, in_last, out_ready,
    input  in_ready, out_cnt, out_valid, out_sat
`ifdef SNC_THERM_OUT_EN
    , input out_therm
`endif
  );

  modport slave (
    input  in_data, in_valid, in_acc, in_last, out_ready,
    output in_ready, out_cnt, out_valid, out_sat
`ifdef SNC_THERM_OUT_EN
    , output out_therm
`endif
  );
endinterface

// File: rtl/sn_popcount_pipe.sv
// Pipelined population counter: odd-even merge bit-sorting network, thermometer decode, frame accumulator.
// Optional macro SNC_THERM_OUT_EN registers and exports the sorted thermometer of pass-through beats.
module sn_popcount_pipe #(
  parameter int N_IN        = 15,
  parameter int ACC_W       = 16,
  parameter int PIPE_STAGES = 2
) (
  input logic               clk,
  input logic               rst_n,
  sn_popcount_pipe_if.slave bus
);
  localparam int CNT_W    = $clog2(N_IN + 1);
  localparam int LG       = $clog2(N_IN);
  localparam int P        = 1 << LG;
  localparam int N_LAYERS = LG * (LG + 1) / 2;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  typedef enum logic {IDLE, ACC} state_t;

  // Network is built on the next power of two; zero padding sinks to the bottom.
  function automatic logic [P-1:0] sort_layers(input logic [P-1:0] v, input int first, input int last);
    logic [P-1:0] r;
    logic a, b;
    int layer;
    r = v;
    layer = 0;
    for (int p = 1; p < P; p = p * 2) begin
      for (int k = p; k >= 1; k = k / 2) begin
        if (layer >= first && layer < last) begin
          for (int j = k % p; j < P - k; j = j + 2 * k) begin
            for (int i = 0; i < k; i++) begin
              if ((i + j + k < P) && ((i + j) / (2 * p) == (i + j + k) / (2 * p))) begin
                a = r[i + j];
                b = r[i + j + k];
                r[i + j + k] = a | b;
                r[i + j]     = a & b;
              end
            end
          end
        end
        layer++;
      end
    end
    return r;
  endfunction

  function automatic int layer_lo(input int s);
    return s * N_LAYERS / PIPE_STAGES;
  endfunction

  logic             advance;
  logic [P-1:0]     in_vec;
  logic [P-1:0]     fin_vec;
  logic             fin_valid, fin_acc, fin_last;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_next;
  logic             sum_ovf;

  state_t           state;
  logic [ACC_W-1:0] acc_sum_q;
  logic             sat_q;
  logic [ACC_W-1:0] out_cnt_q;
  logic             out_valid_q;
  logic             out_sat_q;
`ifdef SNC_THERM_OUT_EN
  logic [N_IN-1:0]  therm_q;
`endif

  assign advance = !out_valid_q || bus.out_ready;
  assign in_vec  = P'(bus.in_data);

  generate
    if (PIPE_STAGES == 1) begin : g_single
      assign fin_vec   = sort_layers(in_vec, 0, N_LAYERS);
      assign fin_valid = bus.in_valid;
      assign fin_acc   = bus.in_acc;
      assign fin_last  = bus.in_last;
    end else begin : g_pipe
      localparam int NR = PIPE_STAGES - 1;
      logic [P-1:0] vec_q   [NR];
      logic         valid_q [NR];
      logic         acc_q   [NR];
      logic         last_q  [NR];

      // Intermediate sorter stages; the whole pipe freezes when the output is blocked.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < NR; s++) begin
            vec_q[s]   <= '0;
            valid_q[s] <= 1'b0;
            acc_q[s]   <= 1'b0;
            last_q[s]  <= 1'b0;
          end
        end else if (advance) begin
          vec_q[0]   <= sort_layers(in_vec, layer_lo(0), layer_lo(1));
          valid_q[0] <= bus.in_valid;
          acc_q[0]   <= bus.in_acc;
          last_q[0]  <= bus.in_last;
          for (int s = 1; s < NR; s++) begin
            vec_q[s]   <= sort_layers(vec_q[s-1], layer_lo(s), layer_lo(s + 1));
            valid_q[s] <= valid_q[s-1];
            acc_q[s]   <= acc_q[s-1];
            last_q[s]  <= last_q[s-1];
          end
        end
      end

      assign fin_vec   = sort_layers(vec_q[NR-1], layer_lo(NR), N_LAYERS);
      assign fin_valid = valid_q[NR-1];
      assign fin_acc   = acc_q[NR-1];
      assign fin_last  = last_q[NR-1];
    end
  endgenerate

  // The lowest set position of the sorted vector gives the count as P minus its index.
  always_comb begin
    cnt = '0;
    for (int k = P - 1; k >= 0; k--) begin
      if (fin_vec[k]) cnt = CNT_W'(P - k);
    end
  end

  assign sum      = {1'b0, acc_sum_q} + (ACC_W + 1)'(cnt);
  assign sum_ovf  = sum[ACC_W];
  assign acc_next = sum_ovf ? ACC_MAX : sum[ACC_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc_sum_q   <= '0;
      sat_q       <= 1'b0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
`ifdef SNC_THERM_OUT_EN
      therm_q     <= '0;
`endif
    end else if (advance) begin
      out_valid_q <= 1'b0;
      if (fin_valid) begin
        case (state)
          IDLE: begin
            if (!fin_acc || fin_last) begin
              out_valid_q <= 1'b1;
              out_cnt_q   <= ACC_W'(cnt);
              out_sat_q   <= 1'b0;
`ifdef SNC_THERM_OUT_EN
              therm_q     <= fin_acc ? '0 : fin_vec[P-1 -: N_IN];
`endif
            end else begin
              acc_sum_q <= ACC_W'(cnt);
              sat_q     <= 1'b0;
              state     <= ACC;
            end
          end
          ACC: begin
            if (fin_last) begin
              out_valid_q <= 1'b1;
              out_cnt_q   <= acc_next;
              out_sat_q   <= sat_q | sum_ovf;
`ifdef SNC_THERM_OUT_EN
              therm_q     <= '0;
`endif
              acc_sum_q   <= '0;
              sat_q       <= 1'b0;
              state       <= IDLE;
            end else begin
              acc_sum_q <= acc_next;
              sat_q     <= sat_q | sum_ovf;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_cnt   = out_cnt_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sat   = out_sat_q;
`ifdef SNC_THERM_OUT_EN
  assign bus.out_therm = therm_q;
`endif

endmodule

// File: tb/tb_sn_popcount_pipe.sv
// Scoreboard bench for sn_popcount_pipe: a 16-bit and a 5-bit accumulator instance share one stimulus stream.
// Expected results come from a frame-level model using $countones and an unbounded running total.
module tb_sn_popcount_pipe;
  localparam int N      = 15;
  localparam int W_A    = 16;
  localparam int W_B    = 5;
  localparam int STAGES = 2;

  typedef struct {
    int              cnt;
    bit              sat;
    logic [N-1:0]    therm;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] drv_data = '0;
  logic         drv_valid = 1'b0;
  logic         drv_acc = 1'b0;
  logic         drv_last = 1'b0;
  logic         drv_out_ready = 1'b1;
  bit           rand_ready = 1'b0;

  int   checks = 0;
  int   errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  bit   in_frame = 1'b0;
  int   total = 0;

  sn_popcount_pipe_if #(.N_IN(N), .ACC_W(W_A)) ifa ();
  sn_popcount_pipe_if #(.N_IN(N), .ACC_W(W_B)) ifb ();

  assign ifa.in_data   = drv_data;
  assign ifa.in_valid  = drv_valid;
  assign ifa.in_acc    = drv_acc;
  assign ifa.in_last   = drv_last;
  assign ifa.out_ready = drv_out_ready;
  assign ifb.in_data   = drv_data;
  assign ifb.in_valid  = drv_valid;
  assign ifb.in_acc    = drv_acc;
  assign ifb.in_last   = drv_last;
  assign ifb.out_ready = drv_out_ready;

  sn_popcount_pipe #(.N_IN(N), .ACC_W(W_A), .PIPE_STAGES(STAGES)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  sn_popcount_pipe #(.N_IN(N), .ACC_W(W_B), .PIPE_STAGES(STAGES)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rand_ready) drv_out_ready = ($urandom_range(0, 9) < 7);
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [N-1:0] therm_of(input int c);
    logic [N-1:0] t;
    t = '0;
    for (int k = 0; k < c; k++) t[N-1-k] = 1'b1;
    return t;
  endfunction

  function automatic exp_t frame_result(input int sum, input int width);
    exp_t e;
    int   max_val;
    max_val = (1 << width) - 1;
    e.cnt   = (sum > max_val) ? max_val : sum;
    e.sat   = (sum > max_val);
    e.therm = '0;
    return e;
  endfunction

  // Frame-level reference: a frame's result is its true total clamped to the output range.
  function automatic void model_beat(input logic [N-1:0] data, input logic acc, input logic last);
    int   c;
    exp_t e;
    c = $countones(data);
    if (!in_frame) begin
      if (!acc || last) begin
        e.cnt   = c;
        e.sat   = 1'b0;
        e.therm = acc ? '0 : therm_of(c);
        q_a.push_back(e);
        q_b.push_back(e);
      end else begin
        in_frame = 1'b1;
        total    = c;
      end
    end else begin
      total += c;
      if (last) begin
        q_a.push_back(frame_result(total, W_A));
        q_b.push_back(frame_result(total, W_B));
        in_frame = 1'b0;
        total    = 0;
      end
    end
  endfunction

  task automatic applyStimulus(input logic [N-1:0] data, input logic acc, input logic last, output int waits);
    bit taken;
    taken = 1'b0;
    waits = 0;
    drv_data  = data;
    drv_valid = 1'b1;
    drv_acc   = acc;
    drv_last  = last;
    while (!taken && waits < 100) begin
      @(negedge clk);
      taken = (ifa.in_ready == 1'b1);
      @(posedge clk);
      #1;
      if (!taken) waits++;
    end
    drv_valid = 1'b0;
    drv_acc   = 1'b0;
    drv_last  = 1'b0;
    if (taken) model_beat(data, acc, last);
    else checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic idle_cycles(input int n, input logic last_noise);
    drv_valid = 1'b0;
    drv_last  = last_noise;
    repeat (n) @(posedge clk);
    #1;
    drv_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rand_ready    = 1'b0;
    drv_out_ready = 1'b1;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_pending", q_a.size() + q_b.size(), 0);
    idle_cycles(2, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_a_out_valid"}, ifa.out_valid, 0);
    checkOutput({tag, "_a_out_cnt"},   ifa.out_cnt,   0);
    checkOutput({tag, "_a_out_sat"},   ifa.out_sat,   0);
    checkOutput({tag, "_a_in_ready"},  ifa.in_ready,  1);
    checkOutput({tag, "_b_out_valid"}, ifb.out_valid, 0);
    checkOutput({tag, "_b_out_cnt"},   ifb.out_cnt,   0);
  endtask

  // Monitor: scoreboard pops on each output transfer; also checks backpressure and stall hold.
  bit             hold_pend = 1'b0;
  logic [W_A-1:0] hold_cnt;
  logic           hold_sat;
  always @(negedge clk) begin
    exp_t ea;
    exp_t eb;
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      checkOutput("in_ready_rule", ifa.in_ready, !ifa.out_valid || drv_out_ready);
      if (hold_pend) begin
        checkOutput("stall_valid", ifa.out_valid, 1);
        checkOutput("stall_cnt",   ifa.out_cnt,   hold_cnt);
        checkOutput("stall_sat",   ifa.out_sat,   hold_sat);
      end
      hold_pend = ifa.out_valid && !drv_out_ready;
      hold_cnt  = ifa.out_cnt;
      hold_sat  = ifa.out_sat;
      if (ifa.out_valid && drv_out_ready) begin
        if (q_a.size() == 0) begin
          checkOutput("a_unexpected_valid", 1, 0);
        end else begin
          ea = q_a.pop_front();
          checkOutput("a_cnt", ifa.out_cnt, ea.cnt);
          checkOutput("a_sat", ifa.out_sat, ea.sat);
`ifdef SNC_THERM_OUT_EN
          checkOutput("a_therm", ifa.out_therm, ea.therm);
`endif
        end
      end
      if (ifb.out_valid && drv_out_ready) begin
        if (q_b.size() == 0) begin
          checkOutput("b_unexpected_valid", 1, 0);
        end else begin
          eb = q_b.pop_front();
          checkOutput("b_cnt", ifb.out_cnt, eb.cnt);
          checkOutput("b_sat", ifb.out_sat, eb.sat);
        end
      end
    end
  end

  initial begin
    int w;
    int lat;
    logic [N-1:0] rdata;
    logic racc, rlast;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle_cycles(2, 1'b0);

    $display("[TB] pass-through latency");
    applyStimulus(15'b010101110010111, 1'b0, 1'b0, w);
    lat = 1;
    while (!ifa.out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency_cycles", lat, STAGES);
    drain();

    $display("[TB] back-to-back beats");
    applyStimulus(15'h0000, 1'b0, 1'b0, w);
    applyStimulus(15'h7FFF, 1'b0, 1'b0, w);
    checkOutput("b2b_wait_beat2", w, 0);
    applyStimulus(15'h0001, 1'b0, 1'b0, w);
    checkOutput("b2b_wait_beat3", w, 0);
    drain();

    $display("[TB] accumulate frame 15+7+9");
    applyStimulus(15'h7FFF, 1'b1, 1'b0, w);
    applyStimulus(15'h007F, 1'b0, 1'b0, w);
    applyStimulus(15'h01FF, 1'b0, 1'b1, w);
    drain();

    $display("[TB] saturating frame then pass-through");
    applyStimulus(15'h7FFF, 1'b1, 1'b0, w);
    applyStimulus(15'h7FFF, 1'b1, 1'b0, w);
    applyStimulus(15'h7FFF, 1'b0, 1'b1, w);
    applyStimulus(15'h0F0F, 1'b0, 1'b0, w);
    drain();

    $display("[TB] in_last without in_valid inside a frame");
    applyStimulus(15'h0007, 1'b1, 1'b0, w);
    idle_cycles(3, 1'b1);
    applyStimulus(15'h0003, 1'b0, 1'b1, w);
    drain();

    $display("[TB] output stall with beats in flight");
    fork
      begin
        applyStimulus(15'h0003, 1'b0, 1'b0, w);
        applyStimulus(15'h0FFF, 1'b0, 1'b0, w);
        applyStimulus(15'h7FF0, 1'b0, 1'b0, w);
        checkOutput("stall_backpressure_seen", (w > 0), 1);
      end
      begin
        drv_out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        drv_out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] reset in the middle of a frame");
    applyStimulus(15'h00FF, 1'b1, 1'b0, w);
    applyStimulus(15'h0101, 1'b0, 1'b0, w);
    idle_cycles(2, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q_a.delete();
    q_b.delete();
    in_frame = 1'b0;
    total    = 0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    applyStimulus(15'h000F, 1'b1, 1'b1, w);
    drain();

    $display("[TB] randomized traffic");
    rand_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      rdata = N'($urandom);
      if ($urandom_range(0, 3) == 0) rdata = '1;
      racc  = ($urandom_range(0, 2) == 0);
      rlast = ($urandom_range(0, 3) == 0);
      applyStimulus(rdata, racc, rlast, w);
      if ($urandom_range(0, 7) == 0) idle_cycles(1, 1'($urandom_range(0, 1)));
    end
    if (in_frame) applyStimulus(15'h7FFF, 1'b0, 1'b1, w);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sn_popcount_pipe.md
Name: sn_popcount_pipe

Overview:
- Parametrised, pipelined N-input population counter. Successor to the fixed 15:4 sorting-network counter.
- Input bits pass through an odd-even merge sorting network built from OR/AND bit-sorter cells. The thermometer result is converted to a binary count.
- Adds pipelining, a valid/ready handshake, and a multi-beat accumulate mode.
- Sits between a partial-product/compressor front end and the downstream adder or accumulator.

Parameters:
- N_IN, 15, number of input bits (2..64).
- CNT_W, $clog2(N_IN+1), per-beat count width (derived; not overridden).
- ACC_W, 16, output/accumulator width (>= CNT_W).
- PIPE_STAGES, 2, register stages from input acceptance to output (1..4). Sorter layers are split evenly across stages; the last stage does thermometer-to-binary conversion and accumulation.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  N_IN  bits to count
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts a beat this cycle
- in_acc  in  1  beat opens or continues an accumulate frame (sampled only in IDLE)
- in_last  in  1  final beat of an accumulate frame
- out_cnt  out  ACC_W  count or accumulated sum
- out_valid  out  1  out_cnt valid
- out_ready  in  1  downstream accepts
- out_sat  out  1  accumulated sum saturated (valid with out_valid)

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset: out_cnt=0, out_valid=0, out_sat=0, all pipeline valid bits 0, accumulator 0, FSM=IDLE. Asserting rst_n mid-frame discards all in-flight beats and the partial sum.
- Handshake:
  - A beat transfers when in_valid && in_ready.
  - in_ready = !out_valid || out_ready; the pipeline stalls globally.
  - While stalled, every stage register and out_cnt/out_sat hold.
  - Output transfers when out_valid && out_ready.
- Latency: a pass-through beat appears on out_cnt PIPE_STAGES cycles after acceptance, absent stalls. Throughput is 1 beat/cycle.
- Count: popcount(in_data), range 0..N_IN, zero-extended to ACC_W. Must equal the sorted-thermometer index of the highest 1.
- Frame FSM (final stage), states IDLE and ACC:
  - IDLE, in_acc=0: emit the beat count; out_sat=0; stay IDLE.
  - IDLE, in_acc=1, in_last=1: single-beat frame; emit the count; stay IDLE.
  - IDLE, in_acc=1, in_last=0: acc=count; no output; go to ACC.
  - ACC, in_last=0: acc+=count; no output.
  - ACC, in_last=1: emit acc+count; acc cleared; go to IDLE. in_acc is ignored in ACC.
- Saturation: if a sum exceeds 2^ACC_W-1, acc clamps to 2^ACC_W-1 and a sticky sat flag is set. The flag appears on out_sat with the frame result and clears when the frame ends.
- Non-emitting beats never raise out_valid and do not consume downstream bandwidth.
- Boundaries:
  - in_data all 0 gives 0; all 1 gives N_IN.
  - A stall while in ACC loses no beats.
  - in_last with in_valid=0 is ignored.

Optional Feature:
- Macro SNC_THERM_OUT_EN.
- Defined: adds output port out_therm [N_IN-1:0]. It carries the sorted thermometer vector (MSB=1 first, ones packed high) of the most recent emitted pass-through beat, aligned with out_valid. It is held during stalls, reset to 0, and 0 for accumulate-frame results.
- Undefined: the port is absent, and the thermometer is not registered at the final stage.

Test Plan:
- N_IN=15, PIPE_STAGES=2: accept in_data=15'b010101110010111 with in_acc=0 -> out_cnt=9 with out_valid 2 cycles later; out_sat=0.
- Back-to-back beats 15'h0000, 15'h7FFF, 15'h0001 with out_ready=1 -> out_cnt 0, 15, 1 on consecutive cycles; in_ready held 1.
- Accumulate frame of 3 beats (counts 15, 7, 9; in_acc=1 on the first, in_last on the third) -> single output out_cnt=31; no out_valid for beats 1-2.
- ACC_W=5, frame of three all-ones beats -> out_cnt=31, out_sat=1; next pass-through beat reports out_sat=0.
- out_ready=0 for 4 cycles with 3 beats in flight -> in_ready=0 once out_valid is set; out_cnt stable; all 3 results delivered in order after release.
- rst_n pulsed low mid-frame after 2 accumulated beats -> outputs 0 immediately (async); the next single-beat frame with count 4 returns 4.
